edge_event_arbiter: RTL and testbench
=====================================

Name: edge_event_arbiter

Overview:
- Watches N asynchronous-free, already clock-domain-local source lines for rising edges.
- Latches each edge as a pending event with a timestamp, then serialises the events onto one valid/ready output stream.
- Uses round-robin arbitration.
- Sits between the per-channel front ends (PMT/trigger inputs) and the event FIFO / host readout path.

Parameters:
- N_CHANNELS, 4, number of source lines (2..16).
- TS_WIDTH, 16, width of the free-running timestamp counter and the reported event time.
- CH_WIDTH, 2, width of the channel index; must equal ceil(log2(N_CHANNELS)), minimum 1.

Ports:
- iClk  input  1  system clock; all logic on its rising edge.
- iReset  input  1  synchronous, active-high reset.
- iSource  input  N_CHANNELS  source lines, already synchronous to iClk.
- iEnable  input  N_CHANNELS  per-channel detect enable; 0 masks new edges.
- iEventReady  input  1  downstream accepts the current event.
- oEventValid  output  1  event on oEventChannel/oEventTime is valid.
- oEventChannel  output  CH_WIDTH  index of the channel that produced the event.
- oEventTime  output  TS_WIDTH  timestamp captured at edge detection.
- oOverflow  output  N_CHANNELS  sticky per-channel lost-edge flag.
- iClearOverflow  input  1  clears all oOverflow bits.

Behaviour:
- **Clock and reset:** one clock, iClk. Reset is synchronous and active-high on iReset.
- **Reset values:** history regs 0, pending 0, timestamp 0, round-robin pointer 0. oEventValid 0, oEventChannel 0, oEventTime 0, oOverflow 0.
- **Reset mid-operation:** pending and in-flight events are discarded with no partial output. The first edge is detectable no earlier than 2 cycles after reset deasserts.
- **Edge detection:**
  - Per channel, a 2-bit history rBuf <= {rBuf[0], iSource[i]}.
  - Edge = ~rBuf[1] & rBuf[0] & iEnable[i].
  - Only 0->1 transitions count. A held-high level produces exactly one edge.
- **Timestamp:** free-running TS_WIDTH counter, +1 every cycle, wraps 2^TS_WIDTH-1 -> 0 silently. An event's time is the counter value in the cycle its edge term is true.
- **Pending latch:**
  - On an edge with pending[i]=0: set pending[i] and store the timestamp in tsStore[i].
  - On an edge with pending[i]=1 that is not being granted this cycle: drop the edge, keep the old timestamp, set oOverflow[i].
  - If pending[i] is granted in the same cycle a new edge arrives: clear-then-set. Pending stays 1 with the new timestamp, and no overflow is flagged.
- **Enable:** deasserting iEnable[i] masks only new edges. An already-pending event is still delivered.
- **Output register:** loads when ~oEventValid | iEventReady.
  - The grant goes to the first pending channel at or after pointer, scanning upward mod N_CHANNELS.
  - On load: oEventValid=1, oEventChannel=index, oEventTime=tsStore[index], pending[index] cleared, pointer=index+1 mod N_CHANNELS.
  - If there is no pending channel and iEventReady=1 while valid, oEventValid drops to 0.
- **Handshake:** standard valid/ready. While oEventValid=1 and iEventReady=0, all outputs hold stable. Back-to-back events with iEventReady tied high give 1 event per cycle.
- **Latency:**
  - iSource first sampled high at clock edge k.
  - The edge term is true during cycle k..k+1, and pending is set at edge k+1.
  - With the output register free, oEventValid is asserted after edge k+2.
- **Simultaneous edges:** all latch in the same cycle and are served in round-robin order from pointer, one per accepted cycle.
- **Overflow:** bits are sticky. iClearOverflow clears them. If iClearOverflow coincides with a new overflow on the same channel, set wins.

Decomposition:
- Shared package holds:
  - a clog2 function for CH_WIDTH;
  - an event record type {channel, time};
  - default constants N_CHANNELS_DEF=4 and TS_WIDTH_DEF=16.
- The per-channel history/edge/pending/timestamp latch is the natural sub-module: edge_event_channel, instantiated N_CHANNELS times.
- The round-robin select and the output register stay in the top level.

Test Plan:
- **Single edge:** after reset, raise iSource[2] at cycle 10 (counter=10), iEventReady=1 -> one event, channel=2, time=11, oEventValid high for exactly 1 cycle, asserted 2 cycles after the sample edge.
- **Simultaneous edges:** all four channels rise in the same cycle, pointer=0, iEventReady=1 -> events on channels 0,1,2,3 in consecutive cycles, all with an identical time.
- **Backpressure:** iEventReady=0 for 20 cycles with channels 1 and 3 pending -> the channel-1 event holds stable. Second rising edge on channel 1 during stall -> oOverflow[1]=1 and the channel-1 time is unchanged. Then release -> channel 1 then channel 3 are delivered. iClearOverflow -> oOverflow=0.
- **Enable mask:** iEnable[0]=0 with a 0->1 on iSource[0] -> no event. Held-high level then iEnable[0]=1 -> still no event. Next 0->1 transition -> event.
- **Timestamp wrap:** edge at counter=16'hFFFF and an edge 3 cycles later -> times 16'hFFFF and 16'h0002, both delivered in order.
- **Reset mid-operation:** iReset asserted for 1 cycle while oEventValid=1 and 2 channels are pending -> next cycle all outputs are 0, and no stale events appear afterwards.

Source files
------------

// File: rtl/edge_event_arbiter_pkg.sv
// Shared definitions for the edge event arbiter: default sizes, channel-index
// width helper and the event record carried on the output stream.
package edge_event_arbiter_pkg;

  localparam int N_CHANNELS_DEF = 4;
  localparam int TS_WIDTH_DEF   = 16;

  // Index width for n channels, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((32'sd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int CH_WIDTH_DEF = clog2_min1(N_CHANNELS_DEF);

  typedef struct packed {
    logic [CH_WIDTH_DEF-1:0] channel;
    logic [TS_WIDTH_DEF-1:0] evt_time;
  } event_rec_t;

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event output stream of the arbiter: valid/ready handshake carrying the
// channel index and the captured timestamp.
interface edge_event_arbiter_if
  import edge_event_arbiter_pkg::*;
#(
  parameter int CH_WIDTH = CH_WIDTH_DEF,
  parameter int TS_WIDTH = TS_WIDTH_DEF
) ();

  logic                oEventValid;
  logic [CH_WIDTH-1:0] oEventChannel;
  logic [TS_WIDTH-1:0] oEventTime;
  logic                iEventReady;

  modport master (
    output oEventValid,
    output oEventChannel,
    output oEventTime,
    input  iEventReady
  );

  modport slave (
    input  oEventValid,
    input  oEventChannel,
    input  oEventTime,
    output iEventReady
  );

endinterface

// File: rtl/edge_event_arbiter_channel.sv
// One source line: rising-edge history, pending flag with its timestamp, and
// the sticky lost-edge flag.
module edge_event_channel
  import edge_event_arbiter_pkg::*;
#(
  parameter int TS_WIDTH = TS_WIDTH_DEF
) (
  input  logic                iClk,
  input  logic                iReset,
  input  logic                i_source,
  input  logic                i_enable,
  input  logic [TS_WIDTH-1:0] i_ts,
  input  logic                i_grant,
  input  logic                i_clear_overflow,
  output logic                o_pending,
  output logic [TS_WIDTH-1:0] o_ts,
  output logic                o_overflow
);

  logic [1:0]          r_buf;
  logic                r_pending;
  logic [TS_WIDTH-1:0] r_ts;
  logic                r_overflow;
  logic                w_edge;

  assign w_edge = ~r_buf[1] & r_buf[0] & i_enable;

  // A grant in the same cycle as a new edge frees the slot, so the new edge
  // re-arms it instead of counting as lost.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_buf      <= 2'b00;
      r_pending  <= 1'b0;
      r_ts       <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_buf <= {r_buf[0], i_source};
      if (w_edge && (!r_pending || i_grant)) begin
        r_pending <= 1'b1;
        r_ts      <= i_ts;
      end else if (i_grant) begin
        r_pending <= 1'b0;
      end
      if (w_edge && r_pending && !i_grant) begin
        r_overflow <= 1'b1;
      end else if (i_clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_pending  = r_pending;
  assign o_ts       = r_ts;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/edge_event_arbiter.sv
// Latches rising edges on N source lines with a timestamp and serialises them
// round-robin onto one registered valid/ready event stream.
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int N_CHANNELS = N_CHANNELS_DEF,
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int CH_WIDTH   = clog2_min1(N_CHANNELS)
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic [N_CHANNELS-1:0] iSource,
  input  logic [N_CHANNELS-1:0] iEnable,
  input  logic                  iClearOverflow,
  output logic [N_CHANNELS-1:0] oOverflow,
  edge_event_arbiter_if.master  evt
);

  logic [TS_WIDTH-1:0] r_ts;
  logic [CH_WIDTH-1:0] r_ptr;
  logic                r_valid;
  logic [CH_WIDTH-1:0] r_channel;
  logic [TS_WIDTH-1:0] r_time;

  logic [N_CHANNELS-1:0] w_pending;
  logic [N_CHANNELS-1:0] w_grant;
  logic [N_CHANNELS-1:0] w_overflow;
  logic [TS_WIDTH-1:0]   w_ts_store [N_CHANNELS];
  logic                  w_load;
  logic                  w_found;
  logic [CH_WIDTH-1:0]   w_idx;

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
    edge_event_channel #(.TS_WIDTH(TS_WIDTH)) u_ch (
      .iClk             (iClk),
      .iReset           (iReset),
      .i_source         (iSource[g]),
      .i_enable         (iEnable[g]),
      .i_ts             (r_ts),
      .i_grant          (w_grant[g]),
      .i_clear_overflow (iClearOverflow),
      .o_pending        (w_pending[g]),
      .o_ts             (w_ts_store[g]),
      .o_overflow       (w_overflow[g])
    );
  end

  assign w_load = ~r_valid | evt.iEventReady;

  // First pending channel at or after the pointer, wrapping modulo N_CHANNELS.
  always_comb begin
    logic [CH_WIDTH:0] v_sum;
    v_sum   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      v_sum = {1'b0, r_ptr} + (CH_WIDTH+1)'(k);
      if (v_sum >= (CH_WIDTH+1)'(N_CHANNELS)) begin
        v_sum = v_sum - (CH_WIDTH+1)'(N_CHANNELS);
      end else begin
        v_sum = v_sum;
      end
      if (!w_found && w_pending[v_sum[CH_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_idx   = v_sum[CH_WIDTH-1:0];
      end else begin
        w_idx = w_idx;
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (w_load && w_found) begin
      w_grant[w_idx] = 1'b1;
    end else begin
      w_grant = '0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  // Output register; channel and time hold when the stream drains empty.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_valid   <= 1'b0;
      r_channel <= '0;
      r_time    <= '0;
      r_ptr     <= '0;
    end else if (w_load) begin
      if (w_found) begin
        r_valid   <= 1'b1;
        r_channel <= w_idx;
        r_time    <= w_ts_store[w_idx];
        if (w_idx == CH_WIDTH'(N_CHANNELS - 1)) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= w_idx + CH_WIDTH'(1);
        end
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign evt.oEventValid   = r_valid;
  assign evt.oEventChannel = r_channel;
  assign evt.oEventTime    = r_time;
  assign oOverflow         = w_overflow;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with hand-computed expectations and a
// bench-side timestamp model.
module tb_edge_event_arbiter;
  import edge_event_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  src;
  logic [3:0]  en;
  logic        clr_ovf;
  logic [3:0]  ovf;
  logic [15:0] ts_model;
  logic [15:0] exp_t;
  logic [15:0] exp_t2;
  event_rec_t  exp_evt;
  int          checks;
  int          errors;
  int          seen_valid;

  edge_event_arbiter_if #(.CH_WIDTH(2), .TS_WIDTH(16)) evt_if ();

  edge_event_arbiter #(.N_CHANNELS(4), .TS_WIDTH(16), .CH_WIDTH(2)) dut (
    .iClk           (clk),
    .iReset         (rst),
    .iSource        (src),
    .iEnable        (en),
    .iClearOverflow (clr_ovf),
    .oOverflow      (ovf),
    .evt            (evt_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    logic rs;
    rs = rst;
    @(posedge clk);
    #1;
    if (rs) ts_model = 16'd0;
    else    ts_model = ts_model + 16'd1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_evt(input string tag, input logic [1:0] ch, input logic [15:0] t);
    check({tag, "_valid"}, 32'(evt_if.oEventValid), 32'd1);
    check({tag, "_ch"}, 32'(evt_if.oEventChannel), 32'(ch));
    check({tag, "_time"}, 32'(evt_if.oEventTime), 32'(t));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ts_model = 16'd0;
    rst = 1'b1;
    src = 4'b0000;
    en = 4'b1111;
    clr_ovf = 1'b0;
    evt_if.iEventReady = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 32'(evt_if.oEventValid), 32'd0);
    check("rst_ch", 32'(evt_if.oEventChannel), 32'd0);
    check("rst_time", 32'(evt_if.oEventTime), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // Single edge on channel 2 raised while the counter reads 10
    for (int i = 0; i < 100 && ts_model != 16'd10; i++) step();
    src = 4'b0100;
    step();
    exp_evt.channel = 2'd2;
    exp_evt.evt_time = ts_model;
    check("single_time_model", 32'(exp_evt.evt_time), 32'd11);
    check("single_k0", 32'(evt_if.oEventValid), 32'd0);
    step();
    check("single_k1", 32'(evt_if.oEventValid), 32'd0);
    step();
    check_evt("single", exp_evt.channel, exp_evt.evt_time);
    step();
    check("single_drop", 32'(evt_if.oEventValid), 32'd0);
    src = 4'b0000;

    // Simultaneous edges on all channels from pointer 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    src = 4'b1111;
    step();
    exp_t = ts_model;
    step();
    step();
    check_evt("sim0", 2'd0, exp_t);
    step();
    check_evt("sim1", 2'd1, exp_t);
    step();
    check_evt("sim2", 2'd2, exp_t);
    step();
    check_evt("sim3", 2'd3, exp_t);
    step();
    check("sim_end", 32'(evt_if.oEventValid), 32'd0);
    src = 4'b0000;
    step();
    step();

    // Backpressure with channels 1 and 3 pending, plus overflow on channel 1
    evt_if.iEventReady = 1'b0;
    src = 4'b1010;
    step();
    exp_t = ts_model;
    step();
    step();
    check_evt("bp_first", 2'd1, exp_t);
    src = 4'b1000;
    step();
    step();
    src = 4'b1010;
    step();
    exp_t2 = ts_model;
    step();
    src = 4'b1000;
    step();
    src = 4'b1010;
    step();
    step();
    check("bp_ovf_set", 32'(ovf), 32'h2);
    check_evt("bp_mid", 2'd1, exp_t);
    for (int i = 0; i < 13; i++) step();
    check_evt("bp_hold", 2'd1, exp_t);
    evt_if.iEventReady = 1'b1;
    step();
    check_evt("bp_rel_ch3", 2'd3, exp_t);
    step();
    check_evt("bp_rel_ch1b", 2'd1, exp_t2);
    step();
    check("bp_end", 32'(evt_if.oEventValid), 32'd0);
    check("bp_ovf_sticky", 32'(ovf), 32'h2);
    src = 4'b0000;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("bp_ovf_clr", 32'(ovf), 32'h0);
    step();

    // Enable mask on channel 0
    en = 4'b1110;
    src = 4'b0001;
    seen_valid = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (evt_if.oEventValid === 1'b1) seen_valid++;
    end
    en = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      if (evt_if.oEventValid === 1'b1) seen_valid++;
    end
    check("en_masked", 32'(seen_valid), 32'd0);
    src = 4'b0000;
    step();
    src = 4'b0001;
    step();
    exp_t = ts_model;
    step();
    step();
    check_evt("en_event", 2'd0, exp_t);
    src = 4'b0000;
    step();
    check("en_end", 32'(evt_if.oEventValid), 32'd0);

    // Timestamp wrap: edges at 16'hFFFF and 3 cycles later
    for (int i = 0; i < 70000 && ts_model != 16'hFFFE; i++) step();
    src = 4'b0010;
    step();
    exp_t = ts_model;
    check("wrap_model", 32'(exp_t), 32'hFFFF);
    step();
    step();
    check_evt("wrap_a", 2'd1, 16'hFFFF);
    src = 4'b0110;
    step();
    check("wrap_gap", 32'(evt_if.oEventValid), 32'd0);
    step();
    step();
    check_evt("wrap_b", 2'd2, 16'h0002);
    src = 4'b0000;
    step();
    step();

    // Reset while an event is presented and two more are pending
    evt_if.iEventReady = 1'b0;
    src = 4'b0111;
    step();
    exp_t = ts_model;
    step();
    step();
    check_evt("mid_pre", 2'd0, exp_t);
    rst = 1'b1;
    src = 4'b0000;
    step();
    rst = 1'b0;
    check("mid_valid", 32'(evt_if.oEventValid), 32'd0);
    check("mid_ch", 32'(evt_if.oEventChannel), 32'd0);
    check("mid_time", 32'(evt_if.oEventTime), 32'd0);
    check("mid_ovf", 32'(ovf), 32'd0);
    evt_if.iEventReady = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (evt_if.oEventValid !== 1'b0) seen_valid++;
    end
    check("mid_no_stale", 32'(seen_valid), 32'd0);
    src = 4'b1000;
    step();
    exp_t = ts_model;
    step();
    step();
    check_evt("post_rst", 2'd3, exp_t);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
